// File: rtl/spu_issue_pkg.sv
// Shared types, widths and helpers for the dual-issue scheduler.
package spu_issue_pkg;

  localparam int unsigned NREGS   = 128;
  localparam int unsigned MAX_LAT = 7;
  localparam int unsigned REG_AW  = 7;
  localparam int unsigned LAT_W   = 3;
  localparam int unsigned SRC_W   = 3 * REG_AW;

  localparam logic [0:31] SPU_NOP = 32'h0;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_t;

  typedef enum logic {
    StPair,
    StSecond
  } state_t;

  typedef struct packed {
    logic [0:31]       instr;
    pipe_t             pipe;
    logic [REG_AW-1:0] rt;
    logic              wr;
    logic [SRC_W-1:0]  src;       // {ra, rb, rc}
    logic [2:0]        use_mask;  // valid bits for {ra, rb, rc}
    logic [LAT_W-1:0]  lat;
  } issue_slot_t;

  // A zero latency is illegal and behaves as one cycle.
  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0) return LAT_W'(1);
    if (lat > LAT_W'(MAX_LAT)) return LAT_W'(MAX_LAT);
    return lat;
  endfunction

  function automatic logic src_hit(input issue_slot_t s, input logic [REG_AW-1:0] r);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (s.use_mask[k] && (s.src[k*REG_AW +: REG_AW] == r)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Decode-to-issue pair handshake plus pipe-facing issue outputs.
interface dual_issue_ctrl_if;
  import spu_issue_pkg::*;

  logic              pair_valid;
  logic              pair_ready;
  logic [0:31]       instr0, instr1;
  logic              pipe0, pipe1;
  logic [REG_AW-1:0] rt0, rt1;
  logic              wr0, wr1;
  logic [SRC_W-1:0]  src0, src1;
  logic [2:0]        use0, use1;
  logic [LAT_W-1:0]  lat0, lat1;
  logic [7:0]        pc_in;
  logic              branch_taken;
  logic [0:31]       instr_even;
  logic [0:31]       instr_odd;
  logic [7:0]        pc;

  modport master (
    output pair_valid, instr0, instr1, pipe0, pipe1, rt0, rt1, wr0, wr1,
           src0, src1, use0, use1, lat0, lat1, pc_in, branch_taken,
    input  pair_ready, instr_even, instr_odd, pc
  );

  modport slave (
    input  pair_valid, instr0, instr1, pipe0, pipe1, rt0, rt1, wr0, wr1,
           src0, src1, use0, use1, lat0, lat1, pc_in, branch_taken,
    output pair_ready, instr_even, instr_odd, pc
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register result-latency counters with two set ports and per-slot hazard queries.
module reg_scoreboard
  import spu_issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set0_i,
  input  logic [REG_AW-1:0] rt0_i,
  input  logic [LAT_W-1:0]  lat0_i,
  input  logic              set1_i,
  input  logic [REG_AW-1:0] rt1_i,
  input  logic [LAT_W-1:0]  lat1_i,
  input  issue_slot_t       q0_i,
  input  issue_slot_t       q1_i,
  output logic              haz0_o,
  output logic              haz1_o
);

  logic [LAT_W-1:0] cnt_q [NREGS];
  logic [LAT_W-1:0] cnt_d [NREGS];

  function automatic logic slot_haz(input issue_slot_t s);
    logic h;
    h = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (s.use_mask[k] && (cnt_q[s.src[k*REG_AW +: REG_AW]] != '0)) h = 1'b1;
    end
    if (s.wr && (cnt_q[s.rt] > eff_lat(s.lat))) h = 1'b1;
    return h;
  endfunction

  assign haz0_o = slot_haz(q0_i);
  assign haz1_o = slot_haz(q1_i);

  // Set port 1 is applied last so the younger slot wins a same-register write.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      if (set0_i && (rt0_i == REG_AW'(r))) cnt_d[r] = eff_lat(lat0_i);
      if (set1_i && (rt1_i == REG_AW'(r))) cnt_d[r] = eff_lat(lat1_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue scheduler: steers an instruction pair to even/odd pipes with hazard stalls.
// Optional performance counters are enabled by defining ISSUE_PERF_EN.
module dual_issue_ctrl
  import spu_issue_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  dual_issue_ctrl_if.slave   bus_io
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        dual_cnt
`endif
);

  issue_slot_t slot0, slot1, slot_b, slot1_q;
  state_t      state_q, state_d;
  logic [0:31] even_q, even_d, odd_q, odd_d;
  logic [7:0]  pc_q, pc_d, pc1_q;
  logic        haz0, haz1, branch, can_dual, issue0, dual, issue_b;

  always_comb begin
    slot0 = '{instr: bus_io.instr0, pipe: pipe_t'(bus_io.pipe0), rt: bus_io.rt0,
              wr: bus_io.wr0, src: bus_io.src0, use_mask: bus_io.use0, lat: bus_io.lat0};
    slot1 = '{instr: bus_io.instr1, pipe: pipe_t'(bus_io.pipe1), rt: bus_io.rt1,
              wr: bus_io.wr1, src: bus_io.src1, use_mask: bus_io.use1, lat: bus_io.lat1};
  end

  // Slot B is the younger instruction: live in PAIR, latched copy in SECOND.
  assign slot_b   = (state_q == StSecond) ? slot1_q : slot1;
  assign branch   = bus_io.branch_taken;
  assign can_dual = (slot0.pipe != slot1.pipe) && !haz1 &&
                    !(slot0.wr && src_hit(slot1, slot0.rt));
  assign issue0   = !branch && (state_q == StPair) && bus_io.pair_valid && !haz0;
  assign dual     = issue0 && can_dual;
  assign issue_b  = dual || (!branch && (state_q == StSecond) && !haz1);

  assign bus_io.pair_ready = reset && (issue_b || (branch && bus_io.pair_valid));

  reg_scoreboard u_sb (
    .clk_i  (clk),
    .rst_ni (reset),
    .set0_i (issue0 && slot0.wr),
    .rt0_i  (slot0.rt),
    .lat0_i (slot0.lat),
    .set1_i (issue_b && slot_b.wr),
    .rt1_i  (slot_b.rt),
    .lat1_i (slot_b.lat),
    .q0_i   (slot0),
    .q1_i   (slot_b),
    .haz0_o (haz0),
    .haz1_o (haz1)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StPair;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPair:   if (issue0 && !dual) state_d = StSecond;
      StSecond: if (branch || issue_b) state_d = StPair;
      default:  state_d = StPair;
    endcase
  end

  always_comb begin
    even_d = SPU_NOP;
    odd_d  = SPU_NOP;
    pc_d   = pc_q;
    if (issue0) begin
      if (slot0.pipe == PIPE_ODD) odd_d = slot0.instr;
      else                        even_d = slot0.instr;
      pc_d = bus_io.pc_in;
    end
    if (issue_b) begin
      if (slot_b.pipe == PIPE_ODD) odd_d = slot_b.instr;
      else                         even_d = slot_b.instr;
      if (!issue0) pc_d = pc1_q;
    end
    if (branch) pc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      even_q  <= SPU_NOP;
      odd_q   <= SPU_NOP;
      pc_q    <= '0;
      pc1_q   <= '0;
      slot1_q <= '0;
    end else begin
      even_q <= even_d;
      odd_q  <= odd_d;
      pc_q   <= pc_d;
      if (issue0 && !dual) begin
        slot1_q <= slot1;
        pc1_q   <= bus_io.pc_in + 8'd1;
      end
    end
  end

  assign bus_io.instr_even = even_q;
  assign bus_io.instr_odd  = odd_q;
  assign bus_io.pc         = pc_q;

`ifdef ISSUE_PERF_EN
  logic [31:0] stall_q, dual_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      dual_q  <= '0;
    end else begin
      if (bus_io.pair_valid && !issue0 && !issue_b) stall_q <= stall_q + 32'd1;
      if (dual) dual_q <= dual_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign dual_cnt  = dual_q;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed self-checking bench for dual_issue_ctrl (ISSUE_PERF_EN optional).
module tb_dual_issue_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dual_issue_ctrl_if bus ();

`ifdef ISSUE_PERF_EN
  logic [31:0] stall_cnt, dual_cnt;
`endif

  dual_issue_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
`ifdef ISSUE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .dual_cnt  (dual_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_slot(input int s, input logic [31:0] instr, input logic pipe,
                            input logic [6:0] rt, input logic wr, input logic [20:0] src,
                            input logic [2:0] use_m, input logic [2:0] lat);
    if (s == 0) begin
      bus.instr0 = instr; bus.pipe0 = pipe; bus.rt0 = rt; bus.wr0 = wr;
      bus.src0 = src; bus.use0 = use_m; bus.lat0 = lat;
    end else begin
      bus.instr1 = instr; bus.pipe1 = pipe; bus.rt1 = rt; bus.wr1 = wr;
      bus.src1 = src; bus.use1 = use_m; bus.lat1 = lat;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bus.pair_valid = 1'b0; bus.branch_taken = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.branch_taken = 1'b0; bus.pc_in = 8'h55; bus.pair_valid = 1'b1;
    drive_slot(0, 32'h1234_5678, 1'b0, 7'd4, 1'b1, 21'd0, 3'b000, 3'd5);
    drive_slot(1, 32'h8765_4321, 1'b1, 7'd9, 1'b1, 21'd0, 3'b000, 3'd5);
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'h0) begin errors++;
      $display("FAIL reset_even: got %h want 0", bus.instr_even); end
    checks++; if (bus.instr_odd !== 32'h0) begin errors++;
      $display("FAIL reset_odd: got %h want 0", bus.instr_odd); end
    checks++; if (bus.pc !== 8'h0) begin errors++;
      $display("FAIL reset_pc: got %h want 0", bus.pc); end
    checks++; if (bus.pair_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b want 0", bus.pair_ready); end
    checks++; if (dut.u_sb.cnt_q[4] !== 3'd0) begin errors++;
      $display("FAIL reset_cnt4: got %0d want 0", dut.u_sb.cnt_q[4]); end
`ifdef ISSUE_PERF_EN
    checks++; if (stall_cnt !== 32'd0 || dual_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cnt, dual_cnt); end
`endif
    @(negedge clk);
    reset = 1'b1; bus.pair_valid = 1'b0;
  endtask

  task automatic test_dual();
    @(negedge clk);
    drive_slot(0, 32'h1111_0001, 1'b0, 7'd4, 1'b1, {7'd1, 7'd2, 7'd3}, 3'b111, 3'd6);
    drive_slot(1, 32'h2222_0002, 1'b1, 7'd9, 1'b1, {7'd10, 7'd11, 7'd12}, 3'b110, 3'd4);
    bus.pc_in = 8'h20; bus.pair_valid = 1'b1;
    #1;
    checks++; if (bus.pair_ready !== 1'b1) begin errors++;
      $display("FAIL dual_ready: got %b want 1", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'h1111_0001 || bus.instr_odd !== 32'h2222_0002) begin
      errors++; $display("FAIL dual_issue: got %h/%h want 11110001/22220002",
                         bus.instr_even, bus.instr_odd); end
    checks++; if (bus.pc !== 8'h20) begin errors++;
      $display("FAIL dual_pc: got %h want 20", bus.pc); end
    checks++; if (dut.u_sb.cnt_q[4] !== 3'd6 || dut.u_sb.cnt_q[9] !== 3'd4) begin errors++;
      $display("FAIL dual_cnt_set: got %0d/%0d want 6/4", dut.u_sb.cnt_q[4], dut.u_sb.cnt_q[9]); end
`ifdef ISSUE_PERF_EN
    checks++; if (dual_cnt !== 32'd1 || stall_cnt !== 32'd0) begin errors++;
      $display("FAIL dual_perf: got %0d/%0d want 1/0", dual_cnt, stall_cnt); end
`endif
    @(negedge clk);
    bus.pair_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'h0 || bus.instr_odd !== 32'h0) begin errors++;
      $display("FAIL dual_idle: got %h/%h want 0/0", bus.instr_even, bus.instr_odd); end
    checks++; if (dut.u_sb.cnt_q[4] !== 3'd5 || dut.u_sb.cnt_q[9] !== 3'd3) begin errors++;
      $display("FAIL dual_cnt_dec: got %0d/%0d want 5/3", dut.u_sb.cnt_q[4], dut.u_sb.cnt_q[9]); end
  endtask

  task automatic test_even_pair();
    do_reset();
    drive_slot(0, 32'hA000_0005, 1'b0, 7'd5, 1'b1, 21'd0, 3'b000, 3'd1);
    drive_slot(1, 32'hB000_0006, 1'b0, 7'd6, 1'b1, 21'd0, 3'b000, 3'd1);
    bus.pc_in = 8'h40; bus.pair_valid = 1'b1;
    #1;
    checks++; if (bus.pair_ready !== 1'b0) begin errors++;
      $display("FAIL even_ready0: got %b want 0", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'hA000_0005 || bus.instr_odd !== 32'h0 ||
                  bus.pc !== 8'h40) begin errors++;
      $display("FAIL even_slot0: got %h/%h pc %h want a0000005/0 pc 40",
               bus.instr_even, bus.instr_odd, bus.pc); end
    @(negedge clk); #1;
    checks++; if (bus.pair_ready !== 1'b1) begin errors++;
      $display("FAIL even_ready1: got %b want 1", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'hB000_0006 || bus.instr_odd !== 32'h0 ||
                  bus.pc !== 8'h41) begin errors++;
      $display("FAIL even_slot1: got %h/%h pc %h want b0000006/0 pc 41",
               bus.instr_even, bus.instr_odd, bus.pc); end
    @(negedge clk);
    bus.pair_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'h0) begin errors++;
      $display("FAIL even_drain: got %h want 0", bus.instr_even); end
  endtask

  task automatic test_raw_split();
    int   gap;
    logic rdy;
    do_reset();
    drive_slot(0, 32'hC000_0004, 1'b0, 7'd4, 1'b1, 21'd0, 3'b000, 3'd2);
    drive_slot(1, 32'hD000_0001, 1'b1, 7'd12, 1'b0, {7'd4, 7'd0, 7'd0}, 3'b100, 3'd1);
    bus.pc_in = 8'h60; bus.pair_valid = 1'b1;
    #1;
    checks++; if (bus.pair_ready !== 1'b0) begin errors++;
      $display("FAIL raw_ready0: got %b want 0", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'hC000_0004 || bus.instr_odd !== 32'h0) begin errors++;
      $display("FAIL raw_slot0: got %h/%h want c0000004/0", bus.instr_even, bus.instr_odd); end
    gap = 0;
    for (int k = 1; k <= 8 && gap == 0; k++) begin
      @(negedge clk); #1;
      rdy = bus.pair_ready;
      @(posedge clk); #1;
      if (rdy) gap = k;
    end
    checks++; if (gap !== 3) begin errors++;
      $display("FAIL raw_gap: got %0d want 3", gap); end
    checks++; if (bus.instr_odd !== 32'hD000_0001 || bus.instr_even !== 32'h0 ||
                  bus.pc !== 8'h61) begin errors++;
      $display("FAIL raw_slot1: got %h/%h pc %h want d0000001/0 pc 61",
               bus.instr_odd, bus.instr_even, bus.pc); end
    @(negedge clk);
    bus.pair_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    drive_slot(0, 32'h1700_0000, 1'b0, 7'd7, 1'b1, 21'd0, 3'b000, 3'd3);
    drive_slot(1, 32'h1400_0000, 1'b1, 7'd20, 1'b1, 21'd0, 3'b000, 3'd1);
    bus.pc_in = 8'h80; bus.pair_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_slot(0, 32'hC700_0007, 1'b0, 7'd21, 1'b0, {7'd7, 7'd0, 7'd0}, 3'b100, 3'd1);
    drive_slot(1, 32'hD000_0007, 1'b1, 7'd22, 1'b0, 21'd0, 3'b000, 3'd1);
    bus.pc_in = 8'h82;
    #1;
    checks++; if (dut.u_sb.cnt_q[7] !== 3'd3) begin errors++;
      $display("FAIL stall_cnt7: got %0d want 3", dut.u_sb.cnt_q[7]); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (bus.pair_ready !== (i == 3)) begin errors++;
        $display("FAIL stall_ready[%0d]: got %b want %b", i, bus.pair_ready, i == 3); end
      @(posedge clk); #1;
      checks++; if (bus.instr_even !== ((i == 3) ? 32'hC700_0007 : 32'h0)) begin errors++;
        $display("FAIL stall_even[%0d]: got %h", i, bus.instr_even); end
    end
    checks++; if (bus.instr_odd !== 32'hD000_0007) begin errors++;
      $display("FAIL stall_odd: got %h want d0000007", bus.instr_odd); end
`ifdef ISSUE_PERF_EN
    checks++; if (stall_cnt !== 32'd3 || dual_cnt !== 32'd2) begin errors++;
      $display("FAIL stall_perf: got %0d/%0d want 3/2", stall_cnt, dual_cnt); end
`endif
    @(negedge clk);
    bus.pair_valid = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    drive_slot(0, 32'hA400_0000, 1'b0, 7'd4, 1'b1, 21'd0, 3'b000, 3'd5);
    drive_slot(1, 32'hB600_0000, 1'b0, 7'd6, 1'b1, {7'd4, 7'd0, 7'd0}, 3'b100, 3'd2);
    bus.pc_in = 8'hA0; bus.pair_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'hA400_0000) begin errors++;
      $display("FAIL br_slot0: got %h want a4000000", bus.instr_even); end
    @(negedge clk);
    bus.branch_taken = 1'b1;
    #1;
    checks++; if (bus.pair_ready !== 1'b1) begin errors++;
      $display("FAIL br_ready: got %b want 1", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'h0 || bus.instr_odd !== 32'h0 || bus.pc !== 8'h0) begin
      errors++; $display("FAIL br_flush: got %h/%h pc %h want 0/0 pc 0",
                         bus.instr_even, bus.instr_odd, bus.pc); end
    checks++; if (dut.u_sb.cnt_q[4] !== 3'd4) begin errors++;
      $display("FAIL br_cnt4: got %0d want 4", dut.u_sb.cnt_q[4]); end
    @(negedge clk);
    bus.branch_taken = 1'b0; bus.pair_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'h0 || bus.instr_odd !== 32'h0) begin errors++;
      $display("FAIL br_dropped: got %h/%h want 0/0", bus.instr_even, bus.instr_odd); end
    checks++; if (dut.u_sb.cnt_q[4] !== 3'd3) begin errors++;
      $display("FAIL br_cnt4_dec: got %0d want 3", dut.u_sb.cnt_q[4]); end
    @(negedge clk);
    drive_slot(0, 32'hE000_0001, 1'b1, 7'd30, 1'b0, 21'd0, 3'b000, 3'd1);
    drive_slot(1, 32'hF000_0002, 1'b0, 7'd31, 1'b0, 21'd0, 3'b000, 3'd1);
    bus.pair_valid = 1'b1;
    #1;
    checks++; if (bus.pair_ready !== 1'b1) begin errors++;
      $display("FAIL br_pair_state: got %b want 1", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (bus.instr_odd !== 32'hE000_0001 || bus.instr_even !== 32'hF000_0002) begin
      errors++; $display("FAIL br_after: got %h/%h want e0000001/f0000002",
                         bus.instr_odd, bus.instr_even); end
    @(negedge clk);
    bus.pair_valid = 1'b0;
  endtask

  task automatic test_reset_stall();
    do_reset();
    drive_slot(0, 32'hA400_0001, 1'b0, 7'd4, 1'b1, 21'd0, 3'b000, 3'd5);
    drive_slot(1, 32'hB400_0001, 1'b1, 7'd13, 1'b0, {7'd4, 7'd0, 7'd0}, 3'b100, 3'd1);
    bus.pc_in = 8'hC0; bus.pair_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.pair_ready !== 1'b0) begin errors++;
      $display("FAIL rst_ready: got %b want 0", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (bus.instr_even !== 32'h0 || bus.instr_odd !== 32'h0 || bus.pc !== 8'h0) begin
      errors++; $display("FAIL rst_outs: got %h/%h pc %h want 0/0 pc 0",
                         bus.instr_even, bus.instr_odd, bus.pc); end
    checks++; if (dut.u_sb.cnt_q[4] !== 3'd0) begin errors++;
      $display("FAIL rst_cnt4: got %0d want 0", dut.u_sb.cnt_q[4]); end
`ifdef ISSUE_PERF_EN
    checks++; if (stall_cnt !== 32'd0 || dual_cnt !== 32'd0) begin errors++;
      $display("FAIL rst_perf: got %0d/%0d want 0/0", stall_cnt, dual_cnt); end
`endif
    @(negedge clk);
    reset = 1'b1; bus.pair_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.instr_odd !== 32'h0) begin errors++;
      $display("FAIL rst_dropped: got %h want 0", bus.instr_odd); end
  endtask

  task automatic test_waw_lat0();
    int   gap;
    logic rdy;
    do_reset();
    drive_slot(0, 32'h0800_0001, 1'b0, 7'd8, 1'b1, 21'd0, 3'b000, 3'd5);
    drive_slot(1, 32'h0900_0001, 1'b1, 7'd9, 1'b0, 21'd0, 3'b000, 3'd1);
    bus.pair_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_slot(0, 32'h0800_0002, 1'b0, 7'd8, 1'b1, 21'd0, 3'b000, 3'd0);
    drive_slot(1, 32'h0900_0002, 1'b1, 7'd9, 1'b0, 21'd0, 3'b000, 3'd1);
    gap = 0;
    for (int k = 1; k <= 10 && gap == 0; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      rdy = bus.pair_ready;
      @(posedge clk); #1;
      if (rdy) gap = k;
    end
    checks++; if (gap !== 5) begin errors++;
      $display("FAIL waw_gap: got %0d want 5", gap); end
    checks++; if (bus.instr_even !== 32'h0800_0002) begin errors++;
      $display("FAIL waw_issue: got %h want 08000002", bus.instr_even); end
    checks++; if (dut.u_sb.cnt_q[8] !== 3'd1) begin errors++;
      $display("FAIL waw_lat0: got %0d want 1", dut.u_sb.cnt_q[8]); end
    @(negedge clk);
    bus.pair_valid = 1'b0;
  endtask

  task automatic test_same_rt();
    do_reset();
    drive_slot(0, 32'h0B00_0001, 1'b0, 7'd11, 1'b1, 21'd0, 3'b000, 3'd3);
    drive_slot(1, 32'h0B00_0002, 1'b1, 7'd11, 1'b1, 21'd0, 3'b000, 3'd6);
    bus.pair_valid = 1'b1;
    #1;
    checks++; if (bus.pair_ready !== 1'b1) begin errors++;
      $display("FAIL same_rt_ready: got %b want 1", bus.pair_ready); end
    @(posedge clk); #1;
    checks++; if (dut.u_sb.cnt_q[11] !== 3'd6) begin errors++;
      $display("FAIL same_rt_cnt: got %0d want 6", dut.u_sb.cnt_q[11]); end
    @(negedge clk);
    bus.pair_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_dual();
    test_even_pair();
    test_raw_split();
    test_stall();
    test_branch();
    test_reset_stall();
    test_waw_lat0();
    test_same_rt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
